bytecode_fetch_decode: RTL and testbench

//  Upstream stage of the VM execute core. Fetches bytecode bytes from a synchronous ROM,

---
 rtl/bytecode_fetch_decode.sv | 147 ++++++++++++++
 tb/tb_bytecode_fetch_decode.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bytecode_fetch_decode.sv
// Bytecode fetch/decode front end: reads one byte every two cycles from a synchronous ROM,
// sizes each instruction from its opcode, and hands it to execute over valid/ready.
module bytecode_fetch_decode #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [47:0]       instr_ops,
  output logic [2:0]        instr_nops,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              illegal
);

  typedef enum logic [1:0] {ST_ADDR, ST_DATA, ST_OUT, ST_HALT} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ipc_q, ipc_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          nops_q, nops_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [47:0]         ops_q, ops_d;
  logic                illegal_q, illegal_d;

  function automatic logic is_illegal(input logic [7:0] op);
    return (op >= 8'h1B) && (op <= 8'h3F);
  endfunction

  // Operand byte count from the opcode alone; condJmp (0A) is provisional until op0 arrives.
  function automatic logic [2:0] op_count(input logic [7:0] op);
    logic [2:0] x, y, z;
    if (op[7]) return 3'd3;
    if (op[6]) begin
      x = (op[5:4] == 2'b00) ? 3'd2 : 3'd1;
      y = (op[3:2] == 2'b00) ? 3'd2 : 3'd1;
      z = (op[1:0] == 2'b01 || op[1:0] == 2'b10) ? 3'd1 : 3'd0;
      return 3'd1 + x + y + z;
    end
    case (op)
      8'h00, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h14, 8'h15, 8'h16, 8'h17: return 3'd3;
      8'h01, 8'h02, 8'h04, 8'h07, 8'h0B, 8'h0E, 8'h0F, 8'h13, 8'h19: return 3'd2;
      8'h0A, 8'h12, 8'h18, 8'h1A:                                   return 3'd5;
      8'h0D, 8'h10:                                                 return 3'd1;
      default:                                                      return 3'd0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ipc_d     = ipc_q;
    cnt_d     = cnt_q;
    nops_d    = nops_q;
    opcode_d  = opcode_q;
    ops_d     = ops_q;
    illegal_d = illegal_q;
    if (jump_valid) begin
      // Redirect wins over everything; any in-flight read or partial instruction is dropped.
      state_d   = ST_ADDR;
      pc_d      = jump_addr;
      cnt_d     = '0;
      ops_d     = '0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          pc_d    = pc_q + PC_ONE;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (cnt_q == 3'd0) begin
            opcode_d = mem_rdata;
            ipc_d    = pc_q - PC_ONE;
            if (is_illegal(mem_rdata)) begin
              illegal_d = 1'b1;
              state_d   = ST_HALT;
            end else begin
              nops_d  = op_count(mem_rdata);
              cnt_d   = 3'd1;
              state_d = (nops_d == 3'd0) ? ST_OUT : ST_ADDR;
            end
          end else begin
            for (int k = 0; k < 6; k++) begin
              if (cnt_q - 3'd1 == 3'(k)) ops_d[8*k +: 8] = mem_rdata;
            end
            if (cnt_q == 3'd1 && opcode_q == 8'h0A)
              nops_d = (mem_rdata[7:6] == 2'b11) ? 3'd5 : 3'd4;
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == nops_d) ? ST_OUT : ST_ADDR;
          end
        end
        ST_OUT: begin
          if (instr_ready) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            ops_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ADDR;
      pc_q      <= RESET_PC;
      ipc_q     <= '0;
      cnt_q     <= '0;
      nops_q    <= '0;
      opcode_q  <= '0;
      ops_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ipc_q     <= ipc_d;
      cnt_q     <= cnt_d;
      nops_q    <= nops_d;
      opcode_q  <= opcode_d;
      ops_q     <= ops_d;
      illegal_q <= illegal_d;
    end
  end

  // The reset state is ADDR, so the read strobe is qualified by reset to keep it low in reset.
  assign mem_rd       = reset && (state_q == ST_ADDR);
  assign mem_addr     = mem_rd ? pc_q : '0;
  assign instr_valid  = (state_q == ST_OUT);
  assign instr_opcode = opcode_q;
  assign instr_ops    = ops_q;
  assign instr_nops   = nops_q;
  assign instr_pc     = ipc_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_bytecode_fetch_decode.sv
// Directed bench for bytecode_fetch_decode: ROM model, instruction-length model and
// a per-cycle compare process, plus hand-computed literal expectations.
module tb_bytecode_fetch_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode;
  logic [47:0] instr_ops;
  logic [2:0]  instr_nops;
  logic [15:0] instr_pc;
  logic        jump_valid = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  logic [7:0]  rom [0:65535];
  logic [15:0] exp_pc = 16'h0000;

  bytecode_fetch_decode #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_ops(instr_ops), .instr_nops(instr_nops), .instr_pc(instr_pc),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

  localparam int CNT [0:26] = '{3,2,2,3,2,0,0,2,3,3,0,2,3,1,2,2,1,0,5,2,3,3,3,3,5,2,5};

  // Total instruction length in bytes at address a; 0 means illegal opcode.
  function automatic int ilen(input logic [15:0] a);
    logic [7:0] op;
    logic [7:0] c;
    int x, y, z;
    op = rom[a];
    c  = rom[a + 16'd1];
    if (op >= 8'h80) return 4;
    if (op >= 8'h40) begin
      x = (op[5:4] == 2'd0) ? 2 : 1;
      y = (op[3:2] == 2'd0) ? 2 : 1;
      z = (op[1:0] == 2'd1 || op[1:0] == 2'd2) ? 1 : 0;
      return 2 + x + y + z;
    end
    if (op >= 8'h1B) return 0;
    if (op == 8'h0A) return (c[7:6] == 2'b11) ? 6 : 5;
    return CNT[op] + 1;
  endfunction

  function automatic logic [47:0] eops(input logic [15:0] a, input int n);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < n - 1; k++) r[8*k +: 8] = rom[a + 16'(k + 1)];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!instr_valid && n < max) begin
      step();
      n++;
    end
    if (!instr_valid) chk("wait_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic jump(input logic [15:0] a);
    jump_valid = 1'b1;
    jump_addr  = a;
    step();
    jump_valid = 1'b0;
  endtask

  // Compare process: outputs sampled on the falling edge against the length model.
  always @(negedge clk) begin
    int n;
    if (!reset) begin
      chk("rst_ctl", {mem_rd, instr_valid, illegal}, 64'd0);
      chk("rst_fields", {mem_addr, instr_opcode, instr_nops, instr_pc}, 64'd0);
      chk("rst_ops", instr_ops, 64'd0);
      exp_pc = 16'h0000;
    end else begin
      if (instr_valid) begin
        n = ilen(exp_pc);
        chk("mdl_opcode", instr_opcode, rom[exp_pc]);
        chk("mdl_nops", instr_nops, n - 1);
        chk("mdl_ops", instr_ops, eops(exp_pc, n));
        chk("mdl_pc", instr_pc, exp_pc);
        chk("mdl_no_rd_while_valid", mem_rd, 64'd0);
        if (instr_ready) exp_pc = exp_pc + 16'(n);
      end
      if (illegal) begin
        chk("mdl_illegal_expected", ilen(exp_pc), 64'd0);
        chk("mdl_halt_no_rd", {mem_rd, instr_valid}, 64'd0);
      end
      if (jump_valid) exp_pc = jump_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    rom[0] = 8'h00; rom[1] = 8'h05; rom[2] = 8'h12; rom[3] = 8'h34;
    rom[4] = 8'h0A; rom[5] = 8'hC0; rom[6] = 8'h10; rom[7] = 8'hAB; rom[8] = 8'hCD; rom[9] = 8'h00;
    rom[10] = 8'h0A; rom[11] = 8'h80; rom[12] = 8'h10; rom[13] = 8'h11; rom[14] = 8'h00;
    rom[15] = 8'h45; rom[16] = 8'hAA; rom[17] = 8'hBB; rom[18] = 8'hCC; rom[19] = 8'hDD;
    rom[20] = 8'hEE;
    rom[21] = 8'h95; rom[22] = 8'h01; rom[23] = 8'h02; rom[24] = 8'h03;
    rom[25] = 8'h05;
    rom[26] = 8'h07; rom[27] = 8'h11; rom[28] = 8'h22;
    rom[29] = 8'h20;
    rom[16'h0100] = 8'h07; rom[16'h0101] = 8'h01; rom[16'h0102] = 8'h02;
    rom[16'h0103] = 8'h07; rom[16'h0104] = 8'hAA; rom[16'h0105] = 8'hBB;
    rom[16'h0200] = 8'h12; rom[16'h0201] = 8'h01; rom[16'h0202] = 8'h02;
    rom[16'h0203] = 8'h03; rom[16'h0204] = 8'h04; rom[16'h0205] = 8'h05;
    rom[16'h0300] = 8'h11;
    rom[16'hFFFD] = 8'h12; rom[16'hFFFE] = 8'hAA; rom[16'hFFFF] = 8'hBB;

    repeat (3) step();
    chk("reset_mem_rd", mem_rd, 64'd0);
    chk("reset_valid", instr_valid, 64'd0);
    reset = 1'b1;

    // First instruction: 4 bytes -> valid 8 cycles after first ADDR.
    wait_valid(40, n);
    chk("first_latency", n, 64'd8);
    chk("first_opcode", instr_opcode, 64'h00);
    chk("first_ops", instr_ops, 64'h341205);
    chk("first_nops", instr_nops, 64'd3);
    chk("first_pc", instr_pc, 64'h0000);

    repeat (20) step();
    chk("stall_valid", instr_valid, 64'd1);
    chk("stall_no_rd", mem_rd, 64'd0);
    chk("stall_ops", instr_ops, 64'h341205);
    instr_ready = 1'b1;
    step();
    chk("after_xfer_rd", mem_rd, 64'd1);
    chk("after_xfer_addr", mem_addr, 64'h0004);

    wait_valid(40, n);
    chk("cj16_latency", n, 64'd12);
    chk("cj16_nops", instr_nops, 64'd5);
    chk("cj16_ops", instr_ops, 64'h00CDAB10C0);
    step();
    wait_valid(40, n);
    chk("cj8_nops", instr_nops, 64'd4);
    chk("cj8_pc", instr_pc, 64'd10);
    step();
    wait_valid(40, n);
    chk("op45_nops", instr_nops, 64'd5);
    chk("op45_ops", instr_ops, 64'hEEDDCCBBAA);
    step();
    wait_valid(40, n);
    chk("op95_nops", instr_nops, 64'd3);
    chk("op95_opcode", instr_opcode, 64'h95);
    step();
    wait_valid(40, n);
    chk("op05_latency", n, 64'd2);
    chk("op05_nops", instr_nops, 64'd0);
    chk("op05_ops", instr_ops, 64'd0);
    step();
    wait_valid(40, n);
    chk("op07_pc", instr_pc, 64'd26);
    step();

    n = 0;
    while (!illegal && n < 10) begin
      step();
      n++;
    end
    chk("illegal_set", illegal, 64'd1);
    repeat (4) step();
    chk("halt_no_rd", mem_rd, 64'd0);
    chk("halt_no_valid", instr_valid, 64'd0);
    jump(16'h0100);
    chk("jump_clears_illegal", illegal, 64'd0);
    chk("jump_fetch_rd", mem_rd, 64'd1);
    chk("jump_fetch_addr", mem_addr, 64'h0100);

    wait_valid(40, n);
    chk("j100_pc", instr_pc, 64'h0100);
    step();
    repeat (3) step();
    chk("mid_operand_in_data", mem_rd, 64'd0);
    jump(16'h0200);
    wait_valid(40, n);
    chk("after_midjump_pc", instr_pc, 64'h0200);
    chk("after_midjump_opcode", instr_opcode, 64'h12);
    chk("after_midjump_ops", instr_ops, 64'h0504030201);

    jump(16'h0300);
    wait_valid(40, n);
    chk("xfer_jump_pc", instr_pc, 64'h0300);
    chk("xfer_jump_nops", instr_nops, 64'd0);

    jump(16'hFFFD);
    wait_valid(40, n);
    chk("wrap_pc", instr_pc, 64'hFFFD);
    chk("wrap_ops", instr_ops, 64'h00120500BBAA);
    step();
    chk("wrap_next_addr", mem_addr, 64'h0003);
    step();
    reset = 1'b0;
    #1;
    chk("async_rst_rd", mem_rd, 64'd0);
    chk("async_rst_fields", {instr_valid, illegal, instr_opcode, instr_pc}, 64'd0);
    chk("async_rst_ops", instr_ops, 64'd0);
    repeat (3) step();
    reset = 1'b1;
    wait_valid(40, n);
    chk("restart_latency", n, 64'd8);
    chk("restart_pc", instr_pc, 64'h0000);
    chk("restart_ops", instr_ops, 64'h341205);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
